char_term_ctrl: RTL and testbench
=================================

# char_term_ctrl

Terminal command front end for the VGA character buffer. It consumes the ASCII byte stream from the CPU and keyboard path and tracks the text cursor (80 columns × 32 rows). Printable characters are written into the character RAM directly. Clear and erase operations are delegated to the buffer-init engine through that engine's enable, partial-line and sequential request pins, and the block stalls its input until the engine has finished.

## Interface
Parameters:
- MAXCOL, 80: columns per row; the column counter runs 0..MAXCOL-1.
- MAXROW, 32: rows; the row counter runs 0..MAXROW-1.
- START_TIMEOUT, 4: cycles allowed for the init engine to raise initWrEn after an arm.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rxData  in  8  input byte.
- rxValid  in  1  rxData is valid.
- rxReady  out  1  byte accepted when rxValid & rxReady at a rising edge.
- testPattern  in  1  when high, a full clear requests sequential fill instead of blanks.
- charWrEn  out  1  one-cycle write strobe to the character RAM.
- charAddress  out  12  {col[6:0], row[4:0]}.
- charData  out  7  character code, rxData[6:0].
- initEnable  out  1  to init engine `enable`; its falling edge starts the engine.
- initPartLine  out  1  to init engine `partLineInit`.
- initPartRow  out  5  to init engine `partLineRow`.
- initPartCol  out  7  to init engine `partLineCol`.
- initSequential  out  1  to init engine `sequentialInit`.
- initBusy  in  1  init engine `initWrEn`.
- cursorCol  out  7  current column, for cursor rendering.
- cursorRow  out  5  current row.

## Operation
- States: IDLE, ESC, CSI, INIT_REQ, INIT_ARM, INIT_WAIT_START, INIT_WAIT_DONE.
- rxReady is high only in IDLE, ESC and CSI.
- IDLE, printable byte 0x20–0x7E:
  - charWrEn=1 and charData=rxData[6:0] at the current address.
  - Cursor advances one column.
  - At col MAXCOL-1, col becomes 0 and the block takes a new-line action.
- New-line action:
  - row = (row+1) mod MAXROW; row 31 wraps to 0.
  - The new row is then erased from col 0 with a partial-line request, partCol=0.
- 0x0D (CR): col becomes 0.
- 0x0A (LF): new-line action; col is unchanged.
- 0x08 (BS): col decrements if col>0; no change at col 0.
- 0x0C (FF): full clear, and the cursor goes to (0,0).
- 0x1B: go to ESC.
- All other bytes, including 0x7F and other controls, are consumed with no effect.
- ESC: '[' (0x5B) goes to CSI; any other byte returns to IDLE and is discarded.
- CSI:
  - 'K': partial erase of the cursor row from the cursor col; the cursor does not move.
  - 'H': cursor goes to (0,0), then IDLE.
  - 'J': full clear plus home.
  - Any other byte: IDLE, discarded.
- Init request sequence (all requests):
  - INIT_REQ: initEnable=1; initPartLine=1 for a partial request.
  - INIT_ARM: initEnable=0; initPartLine held at its INIT_REQ value. Holding it over the edge-detect cycle is mandatory, because the engine reloads its column and row from the part pins only while partLineInit is high.
  - initSequential = testPattern & full-clear, driven in both INIT_REQ and INIT_ARM.
  - initPartRow and initPartCol are held stable from INIT_REQ until INIT_WAIT_DONE exits.
  - INIT_WAIT_START: wait for initBusy=1. If it does not arrive within START_TIMEOUT cycles, go to IDLE.
  - INIT_WAIT_DONE: wait for initBusy=0, then IDLE.
- charWrEn is never asserted in INIT_* states. The character RAM therefore sees no concurrent writers.
- Reset (asynchronous, any state):
  - Outputs: state=IDLE, cursor (0,0), charWrEn=0, charAddress=0, charData=0.
  - init* outputs all 0; rxReady=0 while resetn=0.
  - rxReady rises at the first clock edge after reset release.
  - A reset in the middle of an erase abandons it; the init engine shares resetn and also aborts.

## Timing
- Printable byte accepted at edge T: charWrEn, charAddress and charData are registered and valid in cycle T+1. The cursor update is visible in T+1.
- Throughput in IDLE is one byte per cycle. The write address always reflects the cursor before the advance.
- Erase command accepted at T:
  - INIT_REQ in T+1, INIT_ARM in T+2.
  - The engine goes active at the T+3 edge; initBusy is high from T+3.
  - rxReady is low from T+1 until the cycle after initBusy falls.
- Partial erase from col c occupies 80-c busy cycles. A full clear occupies 2560 busy cycles.
- For a printable at col 79, charWrEn fires in T+1 and INIT_REQ follows in T+2 (write first, then erase of the next row).

## Test plan
- Reset release, then bytes 'A','B' on back-to-back cycles -> writes at addr {0,0}=0x000 data 0x41 and {1,0}=0x020 data 0x42; cursor (2,0).
- Cursor at (5,3), bytes ESC '[' 'K' -> initPartLine=1, partRow=3, partCol=5 for exactly 2 cycles; initEnable=1 for 1 cycle; rxReady low through 75 busy cycles; cursor stays (5,3).
- 80 printables from (0,31) -> the 80th write goes to col 79, row 31; then a partial request with row 0, col 0; cursor (0,0) after 80 busy cycles.
- FF with testPattern=1 -> initSequential=1 in INIT_REQ/INIT_ARM, initPartLine=0; 2560 busy cycles; cursor (0,0). A byte held on rxValid during the clear is accepted only afterwards.
- initBusy tied 0, send ESC '[' 'J' -> INIT_WAIT_START times out after 4 cycles; rxReady returns to 1 and no charWrEn pulse occurs.
- resetn pulled low during INIT_WAIT_DONE -> all outputs 0 immediately; after release, the next printable writes at address 0.

Source files
------------

// File: rtl/char_term_ctrl.sv
// char_term_ctrl: terminal command front end for the VGA character buffer.
// Decodes printable bytes, CR/LF/BS/FF and ESC [ H/J/K sequences, tracks the
// text cursor, writes characters straight into the character RAM and hands
// clear/erase work to the buffer-init engine, stalling input until it is done.
module char_term_ctrl #(
    parameter int MAXCOL        = 80,
    parameter int MAXROW        = 32,
    parameter int START_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic        rxReady,
    input  logic        testPattern,
    output logic        charWrEn,
    output logic [11:0] charAddress,
    output logic [6:0]  charData,
    output logic        initEnable,
    output logic        initPartLine,
    output logic [4:0]  initPartRow,
    output logic [6:0]  initPartCol,
    output logic        initSequential,
    input  logic        initBusy,
    output logic [6:0]  cursorCol,
    output logic [4:0]  cursorRow
);

    localparam int          TW       = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [6:0]  LAST_COL = 7'(MAXCOL - 1);
    localparam logic [4:0]  LAST_ROW = 5'(MAXROW - 1);
    localparam logic [TW-1:0] LAST_TMO = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_ESC             = 3'd1,
        S_CSI             = 3'd2,
        S_INIT_REQ        = 3'd3,
        S_INIT_ARM        = 3'd4,
        S_INIT_WAIT_START = 3'd5,
        S_INIT_WAIT_DONE  = 3'd6
    } state_t;

    // Next row with wrap-around at the bottom of the screen.
    function automatic logic [4:0] row_inc(input logic [4:0] row);
        row_inc = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    endfunction

    state_t        r_state;
    logic [6:0]    r_col;
    logic [4:0]    r_row;
    logic          r_nl_pend;     // new-line erase owed after a wrap write
    logic          r_req_part;    // current init request is a partial line
    logic [TW-1:0] r_tmo_cnt;
    logic          r_rx_ready;
    logic          r_char_wr_en;
    logic [11:0]   r_char_addr;
    logic [6:0]    r_char_data;
    logic          r_init_enable;
    logic          r_init_part_line;
    logic [4:0]    r_init_part_row;
    logic [6:0]    r_init_part_col;
    logic          r_init_seq;

    state_t        w_state_nxt;
    logic [6:0]    w_col_nxt;
    logic [4:0]    w_row_nxt;
    logic          w_nl_pend_nxt;
    logic          w_req_part_nxt;
    logic [4:0]    w_part_row_nxt;
    logic [6:0]    w_part_col_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic          w_wr_nxt;
    logic          w_accept;
    logic          w_is_print;
    logic [4:0]    w_row_inc;
    logic          w_in_req;
    logic          w_ready_nxt;

    assign w_accept   = rxValid & r_rx_ready;
    assign w_is_print = (rxData >= 8'h20) && (rxData <= 8'h7E);
    assign w_row_inc  = row_inc(r_row);

    // Next-state, cursor and request decode; defaults hold everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_nl_pend_nxt  = r_nl_pend;
        w_req_part_nxt = r_req_part;
        w_part_row_nxt = r_init_part_row;
        w_part_col_nxt = r_init_part_col;
        w_tmo_nxt      = r_tmo_cnt;
        w_wr_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_nl_pend) begin
                    // erase the freshly entered row after the wrap write
                    w_state_nxt    = S_INIT_REQ;
                    w_req_part_nxt = 1'b1;
                    w_part_row_nxt = r_row;
                    w_part_col_nxt = 7'd0;
                    w_nl_pend_nxt  = 1'b0;
                end else if (w_accept) begin
                    if (w_is_print) begin
                        w_wr_nxt = 1'b1;
                        if (r_col == LAST_COL) begin
                            w_col_nxt     = 7'd0;
                            w_row_nxt     = w_row_inc;
                            w_nl_pend_nxt = 1'b1;
                        end else begin
                            w_col_nxt = r_col + 7'd1;
                        end
                    end else begin
                        case (rxData)
                            8'h0D: w_col_nxt = 7'd0;
                            8'h0A: begin
                                w_row_nxt      = w_row_inc;
                                w_state_nxt    = S_INIT_REQ;
                                w_req_part_nxt = 1'b1;
                                w_part_row_nxt = w_row_inc;
                                w_part_col_nxt = 7'd0;
                            end
                            8'h08: begin
                                if (r_col != 7'd0) begin
                                    w_col_nxt = r_col - 7'd1;
                                end else begin
                                    w_col_nxt = r_col;
                                end
                            end
                            8'h0C: begin
                                w_col_nxt      = 7'd0;
                                w_row_nxt      = 5'd0;
                                w_state_nxt    = S_INIT_REQ;
                                w_req_part_nxt = 1'b0;
                                w_part_row_nxt = 5'd0;
                                w_part_col_nxt = 7'd0;
                            end
                            8'h1B: w_state_nxt = S_ESC;
                            default: w_state_nxt = S_IDLE;
                        endcase
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ESC: begin
                if (w_accept) begin
                    if (rxData == 8'h5B) begin
                        w_state_nxt = S_CSI;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_ESC;
                end
            end
            S_CSI: begin
                if (w_accept) begin
                    case (rxData)
                        8'h4B: begin
                            w_state_nxt    = S_INIT_REQ;
                            w_req_part_nxt = 1'b1;
                            w_part_row_nxt = r_row;
                            w_part_col_nxt = r_col;
                        end
                        8'h48: begin
                            w_col_nxt   = 7'd0;
                            w_row_nxt   = 5'd0;
                            w_state_nxt = S_IDLE;
                        end
                        8'h4A: begin
                            w_col_nxt      = 7'd0;
                            w_row_nxt      = 5'd0;
                            w_state_nxt    = S_INIT_REQ;
                            w_req_part_nxt = 1'b0;
                            w_part_row_nxt = 5'd0;
                            w_part_col_nxt = 7'd0;
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_state_nxt = S_CSI;
                end
            end
            S_INIT_REQ: w_state_nxt = S_INIT_ARM;
            S_INIT_ARM: begin
                w_state_nxt = S_INIT_WAIT_START;
                w_tmo_nxt   = '0;
            end
            S_INIT_WAIT_START: begin
                if (initBusy) begin
                    w_state_nxt = S_INIT_WAIT_DONE;
                end else if (r_tmo_cnt == LAST_TMO) begin
                    // engine never started; give up rather than hang input
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TW'(1);
                end
            end
            S_INIT_WAIT_DONE: begin
                if (!initBusy) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_INIT_WAIT_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_in_req    = (w_state_nxt == S_INIT_REQ) || (w_state_nxt == S_INIT_ARM);
    assign w_ready_nxt = ((w_state_nxt == S_IDLE) || (w_state_nxt == S_ESC) ||
                          (w_state_nxt == S_CSI)) && !w_nl_pend_nxt;

    // State, cursor and registered outputs; partLine is held through ARM so the
    // engine can reload row/col during its edge-detect cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_col            <= 7'd0;
            r_row            <= 5'd0;
            r_nl_pend        <= 1'b0;
            r_req_part       <= 1'b0;
            r_tmo_cnt        <= '0;
            r_rx_ready       <= 1'b0;
            r_char_wr_en     <= 1'b0;
            r_char_addr      <= 12'd0;
            r_char_data      <= 7'd0;
            r_init_enable    <= 1'b0;
            r_init_part_line <= 1'b0;
            r_init_part_row  <= 5'd0;
            r_init_part_col  <= 7'd0;
            r_init_seq       <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_col            <= w_col_nxt;
            r_row            <= w_row_nxt;
            r_nl_pend        <= w_nl_pend_nxt;
            r_req_part       <= w_req_part_nxt;
            r_tmo_cnt        <= w_tmo_nxt;
            r_rx_ready       <= w_ready_nxt;
            r_char_wr_en     <= w_wr_nxt;
            if (w_wr_nxt) begin
                r_char_addr <= {r_col, r_row};
                r_char_data <= rxData[6:0];
            end
            r_init_enable    <= (w_state_nxt == S_INIT_REQ);
            r_init_part_line <= w_in_req && w_req_part_nxt;
            r_init_part_row  <= w_part_row_nxt;
            r_init_part_col  <= w_part_col_nxt;
            r_init_seq       <= w_in_req && !w_req_part_nxt && testPattern;
        end
    end

    assign rxReady        = r_rx_ready;
    assign charWrEn       = r_char_wr_en;
    assign charAddress    = r_char_addr;
    assign charData       = r_char_data;
    assign initEnable     = r_init_enable;
    assign initPartLine   = r_init_part_line;
    assign initPartRow    = r_init_part_row;
    assign initPartCol    = r_init_part_col;
    assign initSequential = r_init_seq;
    assign cursorCol      = r_col;
    assign cursorRow      = r_row;

endmodule

// File: tb/tb_char_term_ctrl.sv
// Bench for char_term_ctrl: table of simple byte vectors plus hand-written
// erase, wrap, full-clear, timeout and reset sequences. A small model of the
// buffer-init engine answers the init* request pins.
module tb_char_term_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        rxValid = 1'b0;
    logic        rxReady;
    logic        testPattern = 1'b0;
    logic        charWrEn;
    logic [11:0] charAddress;
    logic [6:0]  charData;
    logic        initEnable;
    logic        initPartLine;
    logic [4:0]  initPartRow;
    logic [6:0]  initPartCol;
    logic        initSequential;
    logic        initBusy;
    logic [6:0]  cursorCol;
    logic [4:0]  cursorRow;

    int errors = 0;
    int checks = 0;

    char_term_ctrl #(.MAXCOL(80), .MAXROW(32), .START_TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn), .rxData(rxData), .rxValid(rxValid),
        .rxReady(rxReady), .testPattern(testPattern), .charWrEn(charWrEn),
        .charAddress(charAddress), .charData(charData), .initEnable(initEnable),
        .initPartLine(initPartLine), .initPartRow(initPartRow),
        .initPartCol(initPartCol), .initSequential(initSequential),
        .initBusy(initBusy), .cursorCol(cursorCol), .cursorRow(cursorRow)
    );

    always #5 clk = ~clk;

    // Init engine model: falling edge of enable starts it; busy for 80-col
    // cycles on a partial request, 2560 on a full clear.
    logic eng_en = 1'b1;
    logic eng_prev;
    logic eng_busy;
    int   eng_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eng_prev <= 1'b0;
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
        end else begin
            eng_prev <= initEnable;
            if (eng_en && eng_prev && !initEnable) begin
                eng_busy <= 1'b1;
                eng_cnt  <= initPartLine ? (80 - int'(initPartCol)) : 2560;
            end else if (eng_busy) begin
                if (eng_cnt == 1) eng_busy <= 1'b0;
                else eng_cnt <= eng_cnt - 1;
            end
        end
    end
    assign initBusy = eng_busy;

    typedef struct {
        logic [7:0]  data;
        logic        wr;
        logic [11:0] addr;
        logic [6:0]  col;
        logic [4:0]  row;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted; returns #1 after the accept edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rxData  = b;
        rxValid = 1'b1;
        while (rxReady !== 1'b1 && n < 6000) begin
            step();
            n++;
        end
        chk("send_bound", 32'(n < 6000), 32'd1);
        step();
        rxValid = 1'b0;
    endtask

    // Count cycles (including the current one) with rxReady low.
    task automatic wait_ready(output int n, output int wr);
        n  = 0;
        wr = 0;
        while (rxReady !== 1'b1 && n < 6000) begin
            if (charWrEn) wr++;
            n++;
            step();
        end
        chk("ready_bound", 32'(n < 6000), 32'd1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_wr"},   32'(charWrEn), 32'd0);
        chk({p, "_addr"}, 32'(charAddress), 32'd0);
        chk({p, "_data"}, 32'(charData), 32'd0);
        chk({p, "_col"},  32'(cursorCol), 32'd0);
        chk({p, "_row"},  32'(cursorRow), 32'd0);
        chk({p, "_en"},   32'(initEnable), 32'd0);
        chk({p, "_pl"},   32'(initPartLine), 32'd0);
        chk({p, "_prow"}, 32'(initPartRow), 32'd0);
        chk({p, "_pcol"}, 32'(initPartCol), 32'd0);
        chk({p, "_seq"},  32'(initSequential), 32'd0);
        chk({p, "_rdy"},  32'(rxReady), 32'd0);
    endtask

    task automatic chk_cur(input string p, input int c, input int r);
        chk({p, "_col"}, 32'(cursorCol), 32'(c));
        chk({p, "_row"}, 32'(cursorRow), 32'(r));
    endtask

    initial begin
        int n;
        int wr;
        int bad;

        tbl[0]  = '{8'h41, 1'b1, 12'h000, 7'd1, 5'd0};
        tbl[1]  = '{8'h42, 1'b1, 12'h020, 7'd2, 5'd0};
        tbl[2]  = '{8'h43, 1'b1, 12'h040, 7'd3, 5'd0};
        tbl[3]  = '{8'h08, 1'b0, 12'h000, 7'd2, 5'd0};
        tbl[4]  = '{8'h0D, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[5]  = '{8'h08, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[6]  = '{8'h7F, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[7]  = '{8'h01, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[8]  = '{8'h7E, 1'b1, 12'h000, 7'd1, 5'd0};
        tbl[9]  = '{8'h20, 1'b1, 12'h020, 7'd2, 5'd0};
        tbl[10] = '{8'h1B, 1'b0, 12'h000, 7'd2, 5'd0};
        tbl[11] = '{8'h5B, 1'b0, 12'h000, 7'd2, 5'd0};
        tbl[12] = '{8'h48, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[13] = '{8'h1B, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[14] = '{8'h58, 1'b0, 12'h000, 7'd0, 5'd0};
        tbl[15] = '{8'h78, 1'b1, 12'h000, 7'd1, 5'd0};
        tbl[16] = '{8'h1B, 1'b0, 12'h000, 7'd1, 5'd0};
        tbl[17] = '{8'h5B, 1'b0, 12'h000, 7'd1, 5'd0};
        tbl[18] = '{8'h5A, 1'b0, 12'h000, 7'd1, 5'd0};
        tbl[19] = '{8'h71, 1'b1, 12'h020, 7'd2, 5'd0};

        // reset state
        repeat (3) step();
        chk_zero("rst");
        resetn = 1'b1;
        chk("rdy_pre_edge", 32'(rxReady), 32'd0);
        step();
        chk("rdy_post_edge", 32'(rxReady), 32'd1);

        // table: one byte per cycle from IDLE
        for (int i = 0; i < 20; i++) begin
            send(tbl[i].data);
            chk($sformatf("v%0d_wr", i), 32'(charWrEn), 32'(tbl[i].wr));
            if (tbl[i].wr) begin
                chk($sformatf("v%0d_addr", i), 32'(charAddress), 32'(tbl[i].addr));
                chk($sformatf("v%0d_data", i), 32'(charData), 32'(tbl[i].data[6:0]));
            end
            chk_cur($sformatf("v%0d", i), int'(tbl[i].col), int'(tbl[i].row));
        end

        // position cursor at (5,3), then ESC [ K
        send(8'h0D);
        repeat (3) send(8'h0A);
        repeat (5) send(8'h2E);
        chk_cur("k_pre", 5, 3);
        send(8'h1B); send(8'h5B); send(8'h4B);
        chk("k_t1_en", 32'(initEnable), 32'd1);
        chk("k_t1_pl", 32'(initPartLine), 32'd1);
        chk("k_t1_prow", 32'(initPartRow), 32'd3);
        chk("k_t1_pcol", 32'(initPartCol), 32'd5);
        chk("k_t1_rdy", 32'(rxReady), 32'd0);
        chk("k_t1_seq", 32'(initSequential), 32'd0);
        step();
        chk("k_t2_en", 32'(initEnable), 32'd0);
        chk("k_t2_pl", 32'(initPartLine), 32'd1);
        step();
        chk("k_t3_pl", 32'(initPartLine), 32'd0);
        wait_ready(n, wr);
        chk("k_low_cycles", 32'(n + 2), 32'd78);
        chk("k_no_write", 32'(wr), 32'd0);
        chk("k_end_prow", 32'(initPartRow), 32'd3);
        chk("k_end_pcol", 32'(initPartCol), 32'd5);
        chk_cur("k_post", 5, 3);

        // wrap: 80 printables from (0,31)
        send(8'h0D);
        repeat (28) send(8'h0A);
        chk_cur("wrap_pre", 0, 31);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h30 + 8'(i % 10));
            if (charWrEn !== 1'b1 || charAddress !== {7'(i), 5'd31}) bad++;
        end
        chk("wrap_writes", 32'(bad), 32'd0);
        chk("wrap_last_addr", 32'(charAddress), 32'h9FF);
        chk("wrap_last_data", 32'(charData), 32'h39);
        chk("wrap_t1_en", 32'(initEnable), 32'd0);
        chk("wrap_t1_rdy", 32'(rxReady), 32'd0);
        chk_cur("wrap_t1", 0, 0);
        step();
        chk("wrap_t2_wr", 32'(charWrEn), 32'd0);
        chk("wrap_t2_en", 32'(initEnable), 32'd1);
        chk("wrap_t2_pl", 32'(initPartLine), 32'd1);
        chk("wrap_t2_prow", 32'(initPartRow), 32'd0);
        chk("wrap_t2_pcol", 32'(initPartCol), 32'd0);
        step();
        chk("wrap_t3_pl", 32'(initPartLine), 32'd1);
        wait_ready(n, wr);
        chk("wrap_low_cycles", 32'(n), 32'd82);
        chk_cur("wrap_post", 0, 0);

        // full clear with test pattern; a byte waits on rxValid meanwhile
        send(8'h41);
        testPattern = 1'b1;
        send(8'h0C);
        rxData  = 8'h5A;
        rxValid = 1'b1;
        chk("ff_t1_en", 32'(initEnable), 32'd1);
        chk("ff_t1_seq", 32'(initSequential), 32'd1);
        chk("ff_t1_pl", 32'(initPartLine), 32'd0);
        chk_cur("ff_t1", 0, 0);
        step();
        chk("ff_t2_en", 32'(initEnable), 32'd0);
        chk("ff_t2_seq", 32'(initSequential), 32'd1);
        wait_ready(n, wr);
        chk("ff_low_cycles", 32'(n), 32'd2562);
        chk("ff_no_write", 32'(wr), 32'd0);
        step();
        rxValid = 1'b0;
        testPattern = 1'b0;
        chk("ff_held_wr", 32'(charWrEn), 32'd1);
        chk("ff_held_addr", 32'(charAddress), 32'd0);
        chk("ff_held_data", 32'(charData), 32'h5A);
        chk_cur("ff_held", 1, 0);

        // engine never starts: ESC [ J times out
        eng_en = 1'b0;
        send(8'h1B); send(8'h5B); send(8'h4A);
        wait_ready(n, wr);
        chk("tmo_low_cycles", 32'(n), 32'd6);
        chk("tmo_no_write", 32'(wr), 32'd0);
        chk_cur("tmo", 0, 0);
        eng_en = 1'b1;

        // reset during INIT_WAIT_DONE
        send(8'h61); send(8'h62);
        send(8'h1B); send(8'h5B); send(8'h4B);
        repeat (4) step();
        resetn = 1'b0;
        #1;
        chk_zero("mid");
        step();
        step();
        resetn = 1'b1;
        step();
        send(8'h50);
        chk("post_rst_wr", 32'(charWrEn), 32'd1);
        chk("post_rst_addr", 32'(charAddress), 32'd0);
        chk("post_rst_data", 32'(charData), 32'h50);
        chk_cur("post_rst", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
